// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and coordinate helpers for the VGA path.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned COORD_W  = 10;
  localparam bit          SYNC_POL = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test lo <= cnt < hi on unsigned coordinates.
  function automatic logic in_window(coord_t cnt, coord_t lo, coord_t hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bundle between the sync generator and its consumers (game_of_life, board pins).
interface vga_sync_gen_if;
  import vga_pkg::*;

  logic   use_enable;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  coord_t x_pos;
  coord_t y_pos;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  use_enable,
    output hsync, vsync, video_on, x_pos, y_pos, line_start, frame_start
  );

  modport slave (
    output use_enable,
    input  hsync, vsync, video_on, x_pos, y_pos, line_start, frame_start
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable and synchronous reset; wrap_c flags the enabled N-1 -> 0 step.
module mod_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap_c = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: cascaded h/v counters, combinational sync/video decodes and
// registered one-cycle line/frame start pulses.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);
  import vga_pkg::*;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS    = COORD_W'(H_ACTIVE);
  localparam coord_t HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_VIS    = COORD_W'(V_ACTIVE);
  localparam coord_t VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap_c;
  logic   v_wrap_c;
  logic   line_start_q;
  logic   frame_start_q;

  mod_counter #(
    .N (H_TOTAL),
    .W (COORD_W)
  ) u_h_cnt (
    .clk    (clk),
    .reset  (reset),
    .en     (vga.use_enable),
    .count  (h_cnt),
    .wrap_c (h_wrap_c)
  );

  // Vertical counter steps once per enabled end-of-line, so its wrap marks the full-frame wrap.
  mod_counter #(
    .N (V_TOTAL),
    .W (COORD_W)
  ) u_v_cnt (
    .clk    (clk),
    .reset  (reset),
    .en     (h_wrap_c),
    .count  (v_cnt),
    .wrap_c (v_wrap_c)
  );

  // Pulses mark the cycle in which the counters have just landed on column 0 / origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap_c;
      frame_start_q <= v_wrap_c;
    end
  end

  assign vga.x_pos       = h_cnt;
  assign vga.y_pos       = v_cnt;
  assign vga.video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign vga.hsync       = in_window(h_cnt, HS_BEGIN, HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vga.vsync       = in_window(v_cnt, VS_BEGIN, VS_END) ? SYNC_POL : ~SYNC_POL;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: default 640x480 instance plus a tiny parameter-override instance.
module tb_vga_sync_gen;

  localparam int unsigned BH = 800;
  localparam int unsigned BV = 525;
  localparam int unsigned SH = 12;
  localparam int unsigned SV = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if vif_b ();
  vga_sync_gen_if vif_s ();

  vga_sync_gen u_big (
    .clk   (clk),
    .reset (reset),
    .vga   (vif_b)
  );

  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b1)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .vga   (vif_s)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: number of enabled ticks since the last reset, per instance.
  int unsigned tb_t = 0;
  int unsigned ts_t = 0;
  logic exp_ls_b = 1'b0, exp_fs_b = 1'b0, exp_ls_s = 1'b0, exp_fs_s = 1'b0;

  function automatic int unsigned xof(int unsigned t, int unsigned ht);
    return t % ht;
  endfunction

  function automatic int unsigned yof(int unsigned t, int unsigned ht, int unsigned vt);
    return (t / ht) % vt;
  endfunction

  function automatic logic sync_exp(int unsigned c, int unsigned beg, int unsigned len, logic pol);
    return (c >= beg && c < beg + len) ? pol : ~pol;
  endfunction

  task automatic tick(input logic r, input logic en);
    reset = r;
    vif_b.use_enable = en;
    vif_s.use_enable = en;
    @(posedge clk);
    #1;
    if (r) begin
      tb_t = 0; ts_t = 0;
      exp_ls_b = 1'b0; exp_fs_b = 1'b0; exp_ls_s = 1'b0; exp_fs_s = 1'b0;
    end else if (en) begin
      tb_t++; ts_t++;
      exp_ls_b = (tb_t % BH == 0);
      exp_fs_b = (tb_t % (BH * BV) == 0);
      exp_ls_s = (ts_t % SH == 0);
      exp_fs_s = (ts_t % (SH * SV) == 0);
    end else begin
      exp_ls_b = 1'b0; exp_fs_b = 1'b0; exp_ls_s = 1'b0; exp_fs_s = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom % 2));
      checks++;
      if (vif_b.x_pos !== 10'd0 || vif_b.y_pos !== 10'd0) begin
        errors++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", vif_b.x_pos, vif_b.y_pos);
      end
      checks++;
      if ({vif_b.video_on, vif_b.hsync, vif_b.vsync} !== 3'b111) begin
        errors++; $display("FAIL reset_decodes: got von/hs/vs=%b expected 111",
                           {vif_b.video_on, vif_b.hsync, vif_b.vsync});
      end
      checks++;
      if ({vif_b.line_start, vif_b.frame_start, vif_s.line_start, vif_s.frame_start} !== 4'b0000) begin
        errors++; $display("FAIL reset_pulses: got %b expected 0000",
                           {vif_b.line_start, vif_b.frame_start, vif_s.line_start, vif_s.frame_start});
      end
      checks++;
      if ({vif_s.video_on, vif_s.hsync, vif_s.vsync} !== 3'b100) begin
        errors++; $display("FAIL reset_small_decodes: got von/hs/vs=%b expected 100",
                           {vif_s.video_on, vif_s.hsync, vif_s.vsync});
      end
    end
    tick(1'b0, 1'b1);
    checks++;
    if (vif_b.x_pos !== 10'd1 || vif_s.x_pos !== 10'd1) begin
      errors++; $display("FAIL reset_release_x: got big=%0d small=%0d expected 1", vif_b.x_pos, vif_s.x_pos);
    end
  endtask

  task automatic test_enable_gating();
    int ls_cnt = 0;
    int wraps = 0;
    logic [9:0] prev_x;
    prev_x = vif_b.x_pos;
    for (int i = 0; i < 3200; i++) begin
      tick(1'b0, (i % 4) == 3);
      checks++;
      if (vif_b.x_pos !== 10'(xof(tb_t, BH)) || vif_b.y_pos !== 10'(yof(tb_t, BH, BV))) begin
        errors++; $display("FAIL gating_xy cycle %0d: got (%0d,%0d) expected (%0d,%0d)", i,
                           vif_b.x_pos, vif_b.y_pos, xof(tb_t, BH), yof(tb_t, BH, BV));
      end
      checks++;
      if (vif_b.line_start !== exp_ls_b) begin
        errors++; $display("FAIL gating_line_start cycle %0d: got %b expected %b", i, vif_b.line_start, exp_ls_b);
      end
      if (vif_b.line_start === 1'b1) ls_cnt++;
      if (prev_x == 10'd799 && vif_b.x_pos == 10'd0) wraps++;
      prev_x = vif_b.x_pos;
    end
    checks++;
    if (ls_cnt != 1 || wraps != 1) begin
      errors++; $display("FAIL gating_wrap_count: got pulses=%0d wraps=%0d expected 1/1", ls_cnt, wraps);
    end
    checks++;
    if (vif_b.y_pos !== 10'd1) begin
      errors++; $display("FAIL gating_y_end: got %0d expected 1", vif_b.y_pos);
    end
  endtask

  task automatic test_hsync();
    int ticks = 0;
    int low_cnt = 0;
    int hs_first = -1;
    int hs_last = -1;
    int von_fall = -1;
    int cyc = 0;
    logic prev_hs, prev_von, en;
    logic [9:0] prev_x;
    prev_hs = vif_b.hsync; prev_von = vif_b.video_on; prev_x = vif_b.x_pos;
    while (ticks < 800 && cyc < 6000) begin
      en = 1'($urandom % 2);
      tick(1'b0, en);
      cyc++;
      checks++;
      if (vif_b.hsync !== sync_exp(xof(tb_t, BH), 656, 96, 1'b0) ||
          vif_b.video_on !== (xof(tb_t, BH) < 640 && yof(tb_t, BH, BV) < 480)) begin
        errors++; $display("FAIL hsync_decode x=%0d: got hs/von=%b%b", xof(tb_t, BH), vif_b.hsync, vif_b.video_on);
      end
      if (en) begin
        ticks++;
        if (vif_b.hsync === 1'b0) low_cnt++;
        if (prev_hs === 1'b1 && vif_b.hsync === 1'b0) hs_first = int'(vif_b.x_pos);
        if (prev_hs === 1'b0 && vif_b.hsync === 1'b1) hs_last = int'(prev_x);
        if (prev_von === 1'b1 && vif_b.video_on === 1'b0) von_fall = int'(vif_b.x_pos);
      end
      prev_hs = vif_b.hsync; prev_von = vif_b.video_on; prev_x = vif_b.x_pos;
    end
    checks++;
    if (ticks != 800) begin
      errors++; $display("FAIL hsync_timeout: got %0d enabled ticks expected 800", ticks);
    end
    checks++;
    if (low_cnt != 96 || hs_first != 656 || hs_last != 751) begin
      errors++; $display("FAIL hsync_window: got low=%0d start=%0d end=%0d expected 96/656/751",
                         low_cnt, hs_first, hs_last);
    end
    checks++;
    if (von_fall != 640) begin
      errors++; $display("FAIL video_on_fall: got x=%0d expected 640", von_fall);
    end
  endtask

  task automatic test_mid_line_reset();
    int guard = 0;
    while (xof(tb_t, BH) != 300 && guard < 1000) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (vif_b.x_pos !== 10'd300) begin
      errors++; $display("FAIL midline_reach: got x=%0d expected 300", vif_b.x_pos);
    end
    tick(1'b1, 1'($urandom % 2));
    checks++;
    if (vif_b.x_pos !== 10'd0 || vif_b.y_pos !== 10'd0 || vif_b.line_start !== 1'b0 || vif_b.frame_start !== 1'b0) begin
      errors++; $display("FAIL midline_reset: got (%0d,%0d) ls=%b fs=%b expected (0,0) 0 0",
                         vif_b.x_pos, vif_b.y_pos, vif_b.line_start, vif_b.frame_start);
    end
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    checks++;
    if (vif_b.x_pos !== 10'd5 || vif_b.y_pos !== 10'd0) begin
      errors++; $display("FAIL midline_resume: got (%0d,%0d) expected (5,0)", vif_b.x_pos, vif_b.y_pos);
    end
  endtask

  task automatic test_small_frame();
    int ticks = 0;
    int cyc = 0;
    int fs_cnt = 0;
    int last_fs = -1;
    int hs_hi = 0;
    int vs_hi = 0;
    logic en;
    tick(1'b1, 1'b0);
    while (ticks < 3 * SH * SV && cyc < 2000) begin
      en = 1'($urandom % 3 != 0);
      tick(1'b0, en);
      cyc++;
      checks++;
      if (vif_s.x_pos !== 10'(xof(ts_t, SH)) || vif_s.y_pos !== 10'(yof(ts_t, SH, SV))) begin
        errors++; $display("FAIL small_xy: got (%0d,%0d) expected (%0d,%0d)",
                           vif_s.x_pos, vif_s.y_pos, xof(ts_t, SH), yof(ts_t, SH, SV));
      end
      checks++;
      if (vif_s.hsync !== sync_exp(xof(ts_t, SH), 9, 2, 1'b1) ||
          vif_s.vsync !== sync_exp(yof(ts_t, SH, SV), 5, 1, 1'b1) ||
          vif_s.video_on !== (xof(ts_t, SH) < 8 && yof(ts_t, SH, SV) < 4)) begin
        errors++; $display("FAIL small_decode (%0d,%0d): got hs/vs/von=%b%b%b", xof(ts_t, SH),
                           yof(ts_t, SH, SV), vif_s.hsync, vif_s.vsync, vif_s.video_on);
      end
      checks++;
      if (vif_s.line_start !== exp_ls_s || vif_s.frame_start !== exp_fs_s) begin
        errors++; $display("FAIL small_pulses: got ls/fs=%b%b expected %b%b",
                           vif_s.line_start, vif_s.frame_start, exp_ls_s, exp_fs_s);
      end
      if (en) begin
        ticks++;
        if (vif_s.hsync === 1'b1) hs_hi++;
        if (vif_s.vsync === 1'b1) vs_hi++;
      end
      if (vif_s.frame_start === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          checks++;
          if (ticks - last_fs != int'(SH * SV)) begin
            errors++; $display("FAIL small_frame_period: got %0d expected %0d", ticks - last_fs, SH * SV);
          end
        end
        last_fs = ticks;
      end
    end
    checks++;
    if (fs_cnt != 3 || hs_hi != 42 || vs_hi != 36) begin
      errors++; $display("FAIL small_frame_counts: got fs=%0d hs_hi=%0d vs_hi=%0d expected 3/42/36",
                         fs_cnt, hs_hi, vs_hi);
    end
  endtask

  task automatic test_small_mid_frame_reset();
    int guard = 0;
    while (ts_t % (SH * SV) != 2 * SH + 5 && guard < 500) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (vif_s.x_pos !== 10'd5 || vif_s.y_pos !== 10'd2) begin
      errors++; $display("FAIL midframe_reach: got (%0d,%0d) expected (5,2)", vif_s.x_pos, vif_s.y_pos);
    end
    tick(1'b1, 1'b1);
    checks++;
    if (vif_s.x_pos !== 10'd0 || vif_s.y_pos !== 10'd0 || vif_s.line_start !== 1'b0 || vif_s.frame_start !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: got (%0d,%0d) ls=%b fs=%b expected (0,0) 0 0",
                         vif_s.x_pos, vif_s.y_pos, vif_s.line_start, vif_s.frame_start);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'($urandom % 2));
      checks++;
      if (vif_s.x_pos !== 10'(xof(ts_t, SH)) || vif_s.y_pos !== 10'(yof(ts_t, SH, SV)) ||
          vif_s.line_start !== exp_ls_s) begin
        errors++; $display("FAIL midframe_resume: got (%0d,%0d) ls=%b expected (%0d,%0d) ls=%b",
                           vif_s.x_pos, vif_s.y_pos, vif_s.line_start,
                           xof(ts_t, SH), yof(ts_t, SH, SV), exp_ls_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ls_b = 0;
    int fs_s = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 1700; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (vif_b.x_pos !== 10'(xof(tb_t, BH)) || vif_b.y_pos !== 10'(yof(tb_t, BH, BV)) ||
          vif_b.line_start !== exp_ls_b) begin
        errors++; $display("FAIL b2b_big cycle %0d: got (%0d,%0d) ls=%b expected (%0d,%0d) ls=%b", i,
                           vif_b.x_pos, vif_b.y_pos, vif_b.line_start,
                           xof(tb_t, BH), yof(tb_t, BH, BV), exp_ls_b);
      end
      if (vif_b.line_start === 1'b1) ls_b++;
      if (vif_s.frame_start === 1'b1) fs_s++;
    end
    checks++;
    if (ls_b != 2 || fs_s != 20) begin
      errors++; $display("FAIL b2b_counts: got big_ls=%0d small_fs=%0d expected 2/20", ls_b, fs_s);
    end
  endtask

  initial begin
    vif_b.use_enable = 1'b0;
    vif_s.use_enable = 1'b0;
    test_reset();
    test_enable_gating();
    test_hsync();
    test_mid_line_reset();
    test_small_frame();
    test_small_mid_frame_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
